// File: rtl/counter_ctrl.sv
// Start/stop/pause sequencing controller driving a WIDTH-bit up-counter with done pulse and sticky irq.
// Optional prescaler on the RUN tick is enabled by defining COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             irq_ack,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [PRESC_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} st_t;

  st_t  st;
  logic tick;

  assign state = st;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRESC_W-1:0] psc;

  assign tick = (psc == prescale);

  // Restarts from zero on every (re)entry to counting; holds its value while paused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc <= '0;
    end else if (st == RUN) begin
      if (stop)        psc <= '0;
      else if (!pause) psc <= tick ? '0 : psc + PRESC_W'(1);
    end else if (st == PAUSE) begin
      if (start || stop) psc <= '0;
    end else begin
      psc <= '0;
    end
  end
`else
  logic [31:0] unused_presc;
  assign unused_presc = PRESC_W;
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      irq   <= 1'b0;
    end else begin
      done <= 1'b0;
      // A terminal event below overrides this clear.
      if (irq_ack) irq <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            count <= load_val;
            st    <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else if (pause) begin
            st <= PAUSE;
          end else if (tick) begin
            if (count == term_val) begin
              done <= 1'b1;
              irq  <= 1'b1;
              if (auto_reload) begin
                count <= load_val;
              end else begin
                st   <= DONE;
                busy <= 1'b0;
              end
            end else begin
              count <= count + WIDTH'(1);
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else if (start) begin
            st <= RUN;
          end
        end
        DONE: begin
          if (stop) begin
            st <= IDLE;
          end else if (start) begin
            count <= load_val;
            st    <= RUN;
            busy  <= 1'b1;
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Table-driven bench for counter_ctrl: per-cycle command vectors with hand-computed expected outputs,
// plus hand-written async-reset and prescaler sequences.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, pause, auto_reload, irq_ack;
  logic [3:0] load_val, term_val;
  logic [3:0] count;
  logic [1:0] state;
  logic       busy, done, irq;
`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [3:0] prescale = 4'd0;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(4), .PRESC_W(4)) dut (
    .clk(clk), .reset(rst), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .load_val(load_val), .term_val(term_val), .irq_ack(irq_ack),
`ifdef COUNTER_CTRL_PRESCALE_EN
    .prescale(prescale),
`endif
    .count(count), .state(state), .busy(busy), .done(done), .irq(irq)
  );

  typedef struct {
    logic       start, stop, pause, ar, ack;
    logic [3:0] ld, tm;
    logic [3:0] ec;
    logic [1:0] es;
    logic       eb, ed, ei;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic s, logic p, logic pa, logic ar, logic ack,
                              logic [3:0] ld, logic [3:0] tm,
                              logic [3:0] ec, logic [1:0] es, logic eb, logic ed, logic ei);
    vec_t v;
    v.start = s; v.stop = p; v.pause = pa; v.ar = ar; v.ack = ack;
    v.ld = ld; v.tm = tm; v.ec = ec; v.es = es; v.eb = eb; v.ed = ed; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] ec, input logic [1:0] es,
                     input logic eb, input logic ed, input logic ei);
    nvec++;
    if ({count, state, busy, done, irq} !== {ec, es, eb, ed, ei}) begin
      nerr++;
      $display("FAIL %s: got count=%0d state=%0d busy=%b done=%b irq=%b, want count=%0d state=%0d busy=%b done=%b irq=%b",
               nm, count, state, busy, done, irq, ec, es, eb, ed, ei);
    end
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; pause = 0; irq_ack = 0;
  endtask

  initial begin
    rst = 1'b0; auto_reload = 0; load_val = 0; term_val = 0;
    idle_inputs();

    //        st sp pa ar ak  ld  tm   cnt st b d i
    // one-shot 3 -> 5
    vt.push_back(mk(1, 0, 0, 0, 0,  3,  5,   3, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0,  3,  5,   4, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0,  3,  5,   5, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0,  3,  5,   5, 3, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0,  3,  5,   5, 3, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1,  3,  5,   5, 3, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0,  3,  5,   5, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0,  3,  5,   5, 0, 0, 0, 0));
    // auto-reload 14 -> 1 with wrap; ack colliding with terminal event
    vt.push_back(mk(1, 0, 0, 1, 0, 14,  1,  14, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 14,  1,  15, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 14,  1,   0, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 14,  1,   1, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 14,  1,  14, 1, 1, 1, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 14,  1,  15, 1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 14,  1,   0, 1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 14,  1,   1, 1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 1, 1, 14,  1,  14, 1, 1, 1, 1));
    vt.push_back(mk(0, 0, 0, 1, 1, 14,  1,  15, 1, 1, 0, 0));
    vt.push_back(mk(0, 1, 0, 1, 0, 14,  1,  15, 0, 0, 0, 0));
    // pause/resume without reload, start+stop together
    vt.push_back(mk(1, 0, 0, 0, 0,  2,  9,   2, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0,  2,  9,   3, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0,  2,  9,   4, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0,  2,  9,   4, 2, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0,  2,  9,   4, 2, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0,  2,  9,   4, 2, 1, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0,  2,  9,   4, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0,  2,  9,   5, 1, 1, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0,  2,  9,   5, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0,  2,  9,   2, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0,  2,  9,   2, 2, 1, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0,  2,  9,   2, 0, 0, 0, 0));
    // load == term: terminal on first tick; restart from DONE
    vt.push_back(mk(1, 0, 0, 0, 0,  7,  7,   7, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0,  7,  7,   7, 3, 0, 1, 1));
    vt.push_back(mk(1, 0, 0, 0, 0,  7,  7,   7, 1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0,  7,  7,   7, 3, 0, 1, 1));
    // one-shot across the wrap 15 -> 0
    vt.push_back(mk(1, 0, 0, 0, 0, 15,  0,  15, 1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 15,  0,   0, 1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 15,  0,   0, 3, 0, 1, 1));
    // run up to 7 for the async reset check
    vt.push_back(mk(1, 0, 0, 0, 0,  0, 15,   0, 1, 1, 0, 1));
    for (int k = 1; k <= 7; k++)
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 15, 4'(k), 1, 1, 0, 1));

    // reset state
    repeat (2) @(posedge clk);
    #1 chk("reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      start = vt[i].start; stop = vt[i].stop; pause = vt[i].pause;
      auto_reload = vt[i].ar; irq_ack = vt[i].ack;
      load_val = vt[i].ld; term_val = vt[i].tm;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), vt[i].ec, vt[i].es, vt[i].eb, vt[i].ed, vt[i].ei);
    end

    // asynchronous reset mid-RUN, checked before any clock edge
    @(negedge clk) idle_inputs();
    #2 rst = 1'b0;
    #1 chk("async_reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk("reset_hold", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_idle", 0, 0, 0, 0, 0);

`ifdef COUNTER_CTRL_PRESCALE_EN
    // prescale=2: one tick per 3 clks; terminal 9 clks after the load edge
    @(negedge clk);
    prescale = 4'd2; load_val = 0; term_val = 2; auto_reload = 0; start = 1;
    @(posedge clk);
    #1 chk("psc_load", 0, 1, 1, 0, 0);
    @(negedge clk) start = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (k < 9) chk($sformatf("psc_clk%0d", k), 4'(k / 3), 1, 1, 0, 0);
      else       chk("psc_done", 2, 3, 0, 1, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
